// File: rtl/dbg_sba_pkg.sv
// Shared types and helpers for the SBA-to-memory bridge.
package dbg_sba_pkg;

  localparam int unsigned MaxAddrW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic two_beat;
    logic first_lane;
  } beat_plan_t;

  function automatic logic region_hit(input logic [MaxAddrW-1:0] addr,
                                      input logic [MaxAddrW-1:0] base,
                                      input int unsigned         awidth);
    return (addr >> awidth) == (base >> awidth);
  endfunction

endpackage

// File: rtl/dbg_sba_lane_adapter.sv
// Combinational lane select for write data/byte enables and read-data
// replication between the SBA bus and a narrower target word.
module dbg_sba_lane_adapter #(
  parameter int unsigned BusWidth     = 64,
  parameter int unsigned TgtDataWidth = 32
) (
  input  logic                      lane_i,
  input  logic                      two_beat_i,
  input  logic [BusWidth-1:0]       wdata_i,
  input  logic [BusWidth/8-1:0]     be_i,
  input  logic [BusWidth-1:0]       asm_i,
  output logic [TgtDataWidth-1:0]   tgt_wdata_o,
  output logic [TgtDataWidth/8-1:0] tgt_be_o,
  output logic [BusWidth-1:0]       rdata_o
);

  localparam int unsigned BeW  = BusWidth / 8;
  localparam int unsigned TBeW = TgtDataWidth / 8;

  if (BusWidth == 2 * TgtDataWidth) begin : g_split
    assign tgt_wdata_o = lane_i ? wdata_i[BusWidth-1 -: TgtDataWidth] : wdata_i[TgtDataWidth-1:0];
    assign tgt_be_o    = lane_i ? be_i[BeW-1 -: TBeW] : be_i[TBeW-1:0];
    // Single-beat reads mirror the one fetched word into both halves.
    assign rdata_o = two_beat_i ? asm_i :
                     lane_i     ? {2{asm_i[BusWidth-1 -: TgtDataWidth]}} :
                                  {2{asm_i[TgtDataWidth-1:0]}};
  end else begin : g_pass
    assign tgt_wdata_o = wdata_i;
    assign tgt_be_o    = be_i;
    assign rdata_o     = asm_i;
  end

endmodule

// File: rtl/dbg_sba_mem_bridge.sv
// Bridge from the debug module SBA master port to NumTargets memory-like
// targets: region decode, lane/beat splitting, read-only protection, timeout.
module dbg_sba_mem_bridge
  import dbg_sba_pkg::*;
#(
  parameter int unsigned NumTargets    = 2,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned BusWidth      = 64,
  parameter int unsigned TgtDataWidth  = 32,
  parameter int unsigned TgtAddrWidth  = 16,
  parameter logic [NumTargets-1:0][AddrWidth-1:0] TgtBase = {64'h0000_0000_0001_0000, 64'h0},
  parameter logic [NumTargets-1:0] TgtReadOnly = '0,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     sba_req_i,
  input  logic [AddrWidth-1:0]                     sba_addr_i,
  input  logic                                     sba_we_i,
  input  logic [BusWidth-1:0]                      sba_wdata_i,
  input  logic [BusWidth/8-1:0]                    sba_be_i,
  output logic                                     sba_gnt_o,
  output logic                                     sba_rvalid_o,
  output logic [BusWidth-1:0]                      sba_rdata_o,
  output logic                                     sba_err_o,
  output logic [NumTargets-1:0]                    tgt_req_o,
  output logic                                     tgt_we_o,
  output logic [TgtAddrWidth-1:0]                  tgt_addr_o,
  output logic [TgtDataWidth-1:0]                  tgt_wdata_o,
  output logic [TgtDataWidth/8-1:0]                tgt_be_o,
  input  logic [NumTargets-1:0]                    tgt_gnt_i,
  input  logic [NumTargets-1:0]                    tgt_rvalid_i,
  input  logic [NumTargets-1:0][TgtDataWidth-1:0]  tgt_rdata_i
);

  localparam int unsigned BeW   = BusWidth / 8;
  localparam int unsigned TBeW  = TgtDataWidth / 8;
  localparam int unsigned LaneBit = $clog2(TBeW);
  localparam int unsigned IdxW  = (NumTargets > 1) ? $clog2(NumTargets) : 1;
  localparam int unsigned CntW  = (TimeoutCycles > 255) ? $clog2(TimeoutCycles + 1) : 8;

  state_e                  state_q, state_d;
  logic [TgtAddrWidth-1:0] addr_q, addr_d;
  logic                    we_q, we_d;
  logic [BusWidth-1:0]     wdata_q, wdata_d;
  logic [BeW-1:0]          be_q, be_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  beat_plan_t              plan_q, plan_d;
  logic                    beat_q, beat_d;
  logic                    err_q, err_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [BusWidth-1:0]     asm_q, asm_d;

  logic                    hit;
  logic [IdxW-1:0]         idx;
  beat_plan_t              plan;
  logic                    cur_lane, active, timeout;
  logic [CntW-1:0]         cnt_inc;
  logic [BusWidth-1:0]     rdata_lane;
  logic [TgtDataWidth-1:0] wdata_lane;
  logic [TBeW-1:0]         be_lane;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NumTargets; i++) begin
      if (!hit && region_hit(MaxAddrW'(sba_addr_i), MaxAddrW'(TgtBase[i]), TgtAddrWidth)) begin
        hit = 1'b1;
        idx = IdxW'(i);
      end
    end
  end

  if (BusWidth == 2 * TgtDataWidth) begin : g_plan
    logic lo_any, hi_any;
    assign lo_any = |sba_be_i[TBeW-1:0];
    assign hi_any = |sba_be_i[BeW-1:TBeW];
    assign plan.two_beat   = lo_any & hi_any;
    assign plan.first_lane = (lo_any | hi_any) ? (hi_any & ~lo_any) : sba_addr_i[LaneBit];
    assign tgt_addr_o = active ? ((addr_q & ~TgtAddrWidth'(BeW - 1)) |
                                  (cur_lane ? TgtAddrWidth'(TBeW) : '0)) : '0;
  end else begin : g_noplan
    assign plan = '0;
    assign tgt_addr_o = active ? (addr_q & ~TgtAddrWidth'(TBeW - 1)) : '0;
  end

  assign cur_lane = plan_q.first_lane | beat_q;
  assign active   = ((state_q == REQ) || (state_q == WAIT)) && !err_q;
  assign cnt_inc  = cnt_q + CntW'(1);
  assign timeout  = (TimeoutCycles != 0) && (cnt_inc == CntW'(TimeoutCycles));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    idx_d     = idx_q;
    plan_d    = plan_q;
    beat_d    = beat_q;
    err_d     = err_q;
    cnt_d     = '0;
    asm_d     = asm_q;
    sba_gnt_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sba_req_i && !rst_i) begin
          sba_gnt_o = 1'b1;
          addr_d    = sba_addr_i[TgtAddrWidth-1:0];
          we_d      = sba_we_i;
          wdata_d   = sba_wdata_i;
          be_d      = sba_be_i;
          idx_d     = idx;
          plan_d    = plan;
          beat_d    = 1'b0;
          asm_d     = '0;
          err_d     = !hit || (sba_we_i && (TgtReadOnly[idx] || (sba_be_i == '0)));
          state_d   = REQ;
        end
      end
      // An error flagged at decode still passes through REQ for one cycle
      // (with tgt_req_o masked) so the response timing matches two cycles.
      REQ: begin
        cnt_d = cnt_inc;
        if (err_q) begin
          state_d = RESP;
          cnt_d   = '0;
        end else if (tgt_gnt_i[idx_q]) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          asm_d   = '0;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (tgt_rvalid_i[idx_q]) begin
          cnt_d = '0;
          if (cur_lane) asm_d[BusWidth-1 -: TgtDataWidth] = tgt_rdata_i[idx_q];
          else          asm_d[TgtDataWidth-1:0]           = tgt_rdata_i[idx_q];
          if (plan_q.two_beat && !beat_q) begin
            beat_d  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = RESP;
          end
        end else if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          asm_d   = '0;
          cnt_d   = '0;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      plan_q  <= '0;
      beat_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      plan_q  <= plan_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  dbg_sba_lane_adapter #(
    .BusWidth     (BusWidth),
    .TgtDataWidth (TgtDataWidth)
  ) u_lane (
    .lane_i      (cur_lane),
    .two_beat_i  (plan_q.two_beat),
    .wdata_i     (wdata_q),
    .be_i        (be_q),
    .asm_i       (asm_q),
    .tgt_wdata_o (wdata_lane),
    .tgt_be_o    (be_lane),
    .rdata_o     (rdata_lane)
  );

  assign tgt_req_o    = ((state_q == REQ) && !err_q) ? (NumTargets'(1) << idx_q) : '0;
  assign tgt_we_o     = active & we_q;
  assign tgt_wdata_o  = active ? wdata_lane : '0;
  assign tgt_be_o     = active ? be_lane : '0;
  assign sba_rvalid_o = (state_q == RESP);
  assign sba_err_o    = (state_q == RESP) & err_q;
  assign sba_rdata_o  = ((state_q == RESP) && !err_q && !we_q) ? rdata_lane : '0;

endmodule

// File: tb/tb_dbg_sba_mem_bridge.sv
// Directed self-checking bench for dbg_sba_mem_bridge: target 0 is a ROM at 0,
// target 1 a RAM at 0x1_0000, timeout shortened to 8 cycles.
module tb_dbg_sba_mem_bridge;

  logic              clk = 1'b0;
  logic              rst;
  logic              sba_req, sba_we, sba_gnt, sba_rvalid, sba_err;
  logic [63:0]       sba_addr, sba_wdata, sba_rdata;
  logic [7:0]        sba_be;
  logic [1:0]        tgt_req, tgt_gnt, tgt_rvalid;
  logic              tgt_we;
  logic [15:0]       tgt_addr;
  logic [31:0]       tgt_wdata;
  logic [3:0]        tgt_be;
  logic [1:0][31:0]  tgt_rdata;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  dbg_sba_mem_bridge #(
    .NumTargets    (2),
    .AddrWidth     (64),
    .BusWidth      (64),
    .TgtDataWidth  (32),
    .TgtAddrWidth  (16),
    .TgtBase       ({64'h0000_0000_0001_0000, 64'h0}),
    .TgtReadOnly   (2'b01),
    .TimeoutCycles (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sba_req_i    (sba_req),
    .sba_addr_i   (sba_addr),
    .sba_we_i     (sba_we),
    .sba_wdata_i  (sba_wdata),
    .sba_be_i     (sba_be),
    .sba_gnt_o    (sba_gnt),
    .sba_rvalid_o (sba_rvalid),
    .sba_rdata_o  (sba_rdata),
    .sba_err_o    (sba_err),
    .tgt_req_o    (tgt_req),
    .tgt_we_o     (tgt_we),
    .tgt_addr_o   (tgt_addr),
    .tgt_wdata_o  (tgt_wdata),
    .tgt_be_o     (tgt_be),
    .tgt_gnt_i    (tgt_gnt),
    .tgt_rvalid_i (tgt_rvalid),
    .tgt_rdata_i  (tgt_rdata)
  );

  // Inputs change right after the falling edge; outputs are checked 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    sba_req = 1'b0; sba_addr = '0; sba_we = 1'b0; sba_wdata = '0; sba_be = '0;
    tgt_gnt = '0; tgt_rvalid = '0; tgt_rdata = '0;
  endtask

  task automatic issue(input logic [63:0] a, input logic we, input logic [63:0] wd, input logic [7:0] be);
    sba_req = 1'b1; sba_addr = a; sba_we = we; sba_wdata = wd; sba_be = be;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    issue(64'h104, 1'b0, '0, 8'hF0);
    cyc(); cyc(); #1;
    checks++;
    if ({sba_gnt, sba_rvalid, sba_err, tgt_req, tgt_we} !== 6'b0 || sba_rdata !== '0 || tgt_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b rvalid=%b err=%b tgt_req=%b rdata=%h tgt_addr=%h expected all 0",
               sba_gnt, sba_rvalid, sba_err, tgt_req, sba_rdata, tgt_addr);
    end
    clear_inputs();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_read_hi_lane();
    cyc();
    issue(64'h0000_0000_0000_0104, 1'b0, '0, 8'hF0);
    #1; checks++;
    if (sba_gnt !== 1'b1) begin errors++; $display("FAIL rd1_gnt got=%b exp=1", sba_gnt); end
    cyc(); clear_inputs(); tgt_gnt = 2'b01; #1;
    checks++;
    if (tgt_req !== 2'b01 || tgt_addr !== 16'h0104 || tgt_we !== 1'b0) begin
      errors++; $display("FAIL rd1_tgt_req got req=%b addr=%h we=%b exp req=01 addr=0104 we=0", tgt_req, tgt_addr, tgt_we);
    end
    cyc(); tgt_gnt = '0; tgt_rvalid = 2'b01; tgt_rdata[0] = 32'hDEAD_BEEF; #1;
    checks++;
    if (sba_rvalid !== 1'b0 || tgt_req !== 2'b00) begin
      errors++; $display("FAIL rd1_wait got rvalid=%b req=%b exp 0 00", sba_rvalid, tgt_req);
    end
    cyc(); tgt_rvalid = '0; tgt_rdata = '0; #1;
    checks++;
    if (sba_rvalid !== 1'b1 || sba_err !== 1'b0 || sba_rdata !== 64'hDEAD_BEEF_DEAD_BEEF) begin
      errors++; $display("FAIL rd1_resp got rvalid=%b err=%b rdata=%h exp 1 0 deadbeefdeadbeef", sba_rvalid, sba_err, sba_rdata);
    end
    cyc(); #1;
    checks++;
    if (sba_rvalid !== 1'b0) begin errors++; $display("FAIL rd1_rvalid_one_cycle got=%b exp=0", sba_rvalid); end
  endtask

  task automatic test_two_beat_read();
    int unsigned nvalid;
    nvalid = 0;
    cyc();
    issue(64'h0000_0000_0001_0010, 1'b0, '0, 8'hFF);
    #1; nvalid += int'(sba_rvalid);
    cyc(); clear_inputs(); tgt_gnt = 2'b10; #1; nvalid += int'(sba_rvalid);
    checks++;
    if (tgt_req !== 2'b10 || tgt_addr !== 16'h0010) begin
      errors++; $display("FAIL rd2_beat0 got req=%b addr=%h exp 10 0010", tgt_req, tgt_addr);
    end
    cyc(); tgt_gnt = '0; tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h1111_1111; #1; nvalid += int'(sba_rvalid);
    cyc(); tgt_rvalid = '0; tgt_rdata = '0; tgt_gnt = 2'b10; #1; nvalid += int'(sba_rvalid);
    checks++;
    if (tgt_req !== 2'b10 || tgt_addr !== 16'h0014) begin
      errors++; $display("FAIL rd2_beat1 got req=%b addr=%h exp 10 0014", tgt_req, tgt_addr);
    end
    cyc(); tgt_gnt = '0; tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h2222_2222; #1; nvalid += int'(sba_rvalid);
    cyc(); tgt_rvalid = '0; tgt_rdata = '0; #1; nvalid += int'(sba_rvalid);
    checks++;
    if (sba_rvalid !== 1'b1 || sba_err !== 1'b0 || sba_rdata !== 64'h2222_2222_1111_1111) begin
      errors++; $display("FAIL rd2_resp got rvalid=%b err=%b rdata=%h exp 1 0 2222222211111111", sba_rvalid, sba_err, sba_rdata);
    end
    cyc(); #1; nvalid += int'(sba_rvalid);
    checks++;
    if (nvalid != 1) begin errors++; $display("FAIL rd2_rvalid_count got=%0d exp=1", nvalid); end
  endtask

  task automatic test_ro_write();
    logic saw_req;
    saw_req = 1'b0;
    cyc();
    issue(64'h200, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h0F);
    #1; saw_req |= |tgt_req;
    checks++;
    if (sba_gnt !== 1'b1) begin errors++; $display("FAIL ro_gnt got=%b exp=1", sba_gnt); end
    cyc(); clear_inputs(); #1; saw_req |= |tgt_req;
    checks++;
    if (sba_rvalid !== 1'b0) begin errors++; $display("FAIL ro_early_rvalid got=%b exp=0", sba_rvalid); end
    cyc(); #1; saw_req |= |tgt_req;
    checks++;
    if (sba_rvalid !== 1'b1 || sba_err !== 1'b1 || sba_rdata !== '0) begin
      errors++; $display("FAIL ro_resp got rvalid=%b err=%b rdata=%h exp 1 1 0", sba_rvalid, sba_err, sba_rdata);
    end
    checks++;
    if (saw_req !== 1'b0) begin errors++; $display("FAIL ro_no_tgt_req got=%b exp=0", saw_req); end
  endtask

  task automatic test_unmapped_back_to_back();
    cyc();
    issue(64'h0000_0000_FFFF_0000, 1'b0, '0, 8'hFF);
    #1;
    cyc(); #1;
    checks++;
    if (tgt_req !== 2'b00) begin errors++; $display("FAIL um_tgt_req got=%b exp=00", tgt_req); end
    // Next request already pending while the error response is out.
    cyc(); issue(64'h0000_0000_0001_0008, 1'b1, 64'h1122_3344_5566_7788, 8'hF0); #1;
    checks++;
    if (sba_rvalid !== 1'b1 || sba_err !== 1'b1 || sba_rdata !== '0 || sba_gnt !== 1'b0) begin
      errors++; $display("FAIL um_resp got rvalid=%b err=%b rdata=%h gnt=%b exp 1 1 0 0", sba_rvalid, sba_err, sba_rdata, sba_gnt);
    end
    cyc(); #1;
    checks++;
    if (sba_gnt !== 1'b1) begin errors++; $display("FAIL um_next_gnt got=%b exp=1", sba_gnt); end
    cyc(); clear_inputs(); tgt_gnt = 2'b10; #1;
    checks++;
    if (tgt_req !== 2'b10 || tgt_we !== 1'b1 || tgt_addr !== 16'h000C || tgt_wdata !== 32'h1122_3344 || tgt_be !== 4'hF) begin
      errors++; $display("FAIL wr_tgt got req=%b we=%b addr=%h wdata=%h be=%h exp 10 1 000c 11223344 f",
                         tgt_req, tgt_we, tgt_addr, tgt_wdata, tgt_be);
    end
    cyc(); tgt_gnt = '0; tgt_rvalid = 2'b10; tgt_rdata[1] = 32'hFFFF_FFFF; #1;
    checks++;
    if (tgt_wdata !== 32'h1122_3344 || tgt_addr !== 16'h000C) begin
      errors++; $display("FAIL wr_hold got wdata=%h addr=%h exp 11223344 000c", tgt_wdata, tgt_addr);
    end
    cyc(); clear_inputs(); #1;
    checks++;
    if (sba_rvalid !== 1'b1 || sba_err !== 1'b0 || sba_rdata !== '0) begin
      errors++; $display("FAIL wr_resp got rvalid=%b err=%b rdata=%h exp 1 0 0", sba_rvalid, sba_err, sba_rdata);
    end
  endtask

  task automatic test_timeout();
    int unsigned req_cycles;
    req_cycles = 0;
    cyc();
    issue(64'h0000_0000_0001_0020, 1'b0, '0, 8'h0F);
    #1;
    for (int i = 0; i < 8; i++) begin
      cyc(); clear_inputs(); #1;
      if (tgt_req == 2'b10) req_cycles++;
    end
    checks++;
    if (req_cycles != 8) begin errors++; $display("FAIL to_req_cycles got=%0d exp=8", req_cycles); end
    cyc(); tgt_rvalid = 2'b10; tgt_rdata[1] = 32'hBAD0_BAD0; #1;
    checks++;
    if (tgt_req !== 2'b00 || sba_rvalid !== 1'b1 || sba_err !== 1'b1 || sba_rdata !== '0) begin
      errors++; $display("FAIL to_resp got req=%b rvalid=%b err=%b rdata=%h exp 00 1 1 0", tgt_req, sba_rvalid, sba_err, sba_rdata);
    end
    cyc(); #1;
    cyc(); clear_inputs(); #1;
    checks++;
    if (sba_rvalid !== 1'b0 || tgt_req !== 2'b00) begin
      errors++; $display("FAIL to_late_rvalid got rvalid=%b req=%b exp 0 00", sba_rvalid, tgt_req);
    end
  endtask

  task automatic test_reset_in_wait();
    cyc();
    issue(64'h8, 1'b0, '0, 8'h0F);
    #1;
    cyc(); clear_inputs(); tgt_gnt = 2'b01; #1;
    cyc(); tgt_gnt = '0; rst = 1'b1; #1;
    checks++;
    if (tgt_addr !== 16'h0008) begin errors++; $display("FAIL rw_wait_addr got=%h exp=0008", tgt_addr); end
    cyc(); rst = 1'b0; tgt_rvalid = 2'b01; tgt_rdata[0] = 32'h5555_5555; #1;
    checks++;
    if ({sba_gnt, sba_rvalid, sba_err, tgt_req, tgt_we} !== 6'b0 || tgt_addr !== '0 || tgt_be !== '0 || sba_rdata !== '0) begin
      errors++; $display("FAIL rw_after_reset got gnt=%b rvalid=%b req=%b addr=%h be=%h exp all 0",
                         sba_gnt, sba_rvalid, tgt_req, tgt_addr, tgt_be);
    end
    cyc(); clear_inputs(); #1;
    checks++;
    if (sba_rvalid !== 1'b0) begin errors++; $display("FAIL rw_no_rvalid got=%b exp=0", sba_rvalid); end
    // Fresh read with a target that grants one cycle late.
    cyc(); issue(64'h8, 1'b0, '0, 8'h0F); #1;
    cyc(); clear_inputs(); #1;
    cyc(); tgt_gnt = 2'b01; #1;
    checks++;
    if (tgt_req !== 2'b01 || tgt_addr !== 16'h0008 || tgt_be !== 4'hF) begin
      errors++; $display("FAIL rw_fresh_req got req=%b addr=%h be=%h exp 01 0008 f", tgt_req, tgt_addr, tgt_be);
    end
    cyc(); tgt_gnt = '0; #1;
    cyc(); tgt_rvalid = 2'b01; tgt_rdata[0] = 32'hCAFE_F00D; #1;
    cyc(); clear_inputs(); #1;
    checks++;
    if (sba_rvalid !== 1'b1 || sba_err !== 1'b0 || sba_rdata !== 64'hCAFE_F00D_CAFE_F00D) begin
      errors++; $display("FAIL rw_fresh_resp got rvalid=%b err=%b rdata=%h exp 1 0 cafef00dcafef00d", sba_rvalid, sba_err, sba_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_read_hi_lane();
    test_two_beat_read();
    test_ro_write();
    test_unmapped_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
